// File: rtl/bmu_wb_queue_if.sv
// Issue and writeback handshake bundle between the BMU pipeline and its result queue.
// The queue side uses the slave modport; the driving environment uses master.
interface bmu_wb_queue_if;
  logic        valid_in;
  logic [4:0]  rd_addr_in;
  logic [31:0] result_ff;
  logic        error;
  logic        issue_ready_out;
  logic        wb_valid_out;
  logic [4:0]  wb_rd_out;
  logic [31:0] wb_data_out;
  logic        wb_error_out;
  logic        wb_ready_in;

  modport slave (
    input  valid_in, rd_addr_in, result_ff, error, wb_ready_in,
    output issue_ready_out, wb_valid_out, wb_rd_out, wb_data_out, wb_error_out
  );

  modport master (
    output valid_in, rd_addr_in, result_ff, error, wb_ready_in,
    input  issue_ready_out, wb_valid_out, wb_rd_out, wb_data_out, wb_error_out
  );
endinterface

// File: rtl/bmu_wb_queue.sv
// Result queue between the BMU and the register-file writeback port.
// One-cycle capture stage aligns rd with result_ff, then a DEPTH-entry FIFO.
module bmu_wb_queue #(
  parameter int DEPTH = 4,
  parameter int ERR_W = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic              clk,
  input  logic              rst_l,
  bmu_wb_queue_if.slave     bus,
  input  logic              flush_in,
  output logic [CW-1:0]     count_out,
  output logic              overflow_out,
  output logic [ERR_W-1:0]  err_cnt_out
);

  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  logic              pend_v_r;
  logic [4:0]        pend_rd_r;
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic              overflow_r;
  logic [ERR_W-1:0]  err_cnt_r;
  logic [4:0]        mem_rd_r   [DEPTH];
  logic [31:0]       mem_data_r [DEPTH];
  logic              mem_err_r  [DEPTH];

  logic              push_s;
  logic              pop_s;
  logic              accept_s;
  logic              drop_s;
  logic [CW-1:0]     count_nxt_s;

  // Push/pop qualification; flush overrides both, and x0 results never push.
  always_comb begin
    push_s      = 1'b0;
    pop_s       = 1'b0;
    accept_s    = 1'b0;
    drop_s      = 1'b0;
    count_nxt_s = count_r;
    if (!flush_in) begin
      push_s   = pend_v_r && (pend_rd_r != 5'd0);
      pop_s    = (count_r != {CW{1'b0}}) && bus.wb_ready_in;
      accept_s = push_s && ((count_r != FULL_C) || pop_s);
      drop_s   = push_s && (count_r == FULL_C) && !pop_s;
      if (accept_s && !pop_s) begin
        count_nxt_s = count_r + {{AW{1'b0}}, 1'b1};
      end else if (pop_s && !accept_s) begin
        count_nxt_s = count_r - {{AW{1'b0}}, 1'b1};
      end else begin
        count_nxt_s = count_r;
      end
    end else begin
      count_nxt_s = {CW{1'b0}};
    end
  end

  // Capture stage, pointers, occupancy and sticky status.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      pend_v_r   <= 1'b0;
      pend_rd_r  <= 5'd0;
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
      overflow_r <= 1'b0;
      err_cnt_r  <= {ERR_W{1'b0}};
    end else begin
      pend_v_r  <= bus.valid_in & ~flush_in;
      pend_rd_r <= bus.rd_addr_in;
      count_r   <= count_nxt_s;
      if (flush_in) begin
        wr_ptr_r <= {AW{1'b0}};
        rd_ptr_r <= {AW{1'b0}};
      end else begin
        if (accept_s) begin
          wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
        end
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
      if (accept_s && bus.error && (err_cnt_r != {ERR_W{1'b1}})) begin
        err_cnt_r <= err_cnt_r + {{(ERR_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Entry storage; contents are only meaningful below count_r, so no reset.
  always_ff @(posedge clk) begin
    if (rst_l && accept_s) begin
      mem_rd_r[wr_ptr_r]   <= pend_rd_r;
      mem_data_r[wr_ptr_r] <= bus.result_ff;
      mem_err_r[wr_ptr_r]  <= bus.error;
    end
  end

  assign bus.wb_valid_out    = (count_r != {CW{1'b0}});
  assign bus.wb_rd_out       = mem_rd_r[rd_ptr_r];
  assign bus.wb_data_out     = mem_data_r[rd_ptr_r];
  assign bus.wb_error_out    = mem_err_r[rd_ptr_r];
  assign bus.issue_ready_out = (({1'b0, count_r} + {{CW{1'b0}}, pend_v_r}) < {1'b0, FULL_C});
  assign count_out           = count_r;
  assign overflow_out        = overflow_r;
  assign err_cnt_out         = err_cnt_r;

endmodule

// File: tb/tb_bmu_wb_queue.sv
// Randomized and directed bench for bmu_wb_queue against a queue-based reference model.
module tb_bmu_wb_queue;
  localparam int DEPTH = 4;
  localparam int ERR_W = 8;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] d;
    logic        e;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        flush_in;
  logic [2:0]  count_out;
  logic        overflow_out;
  logic [7:0]  err_cnt_out;

  bmu_wb_queue_if bus ();

  bmu_wb_queue #(.DEPTH(DEPTH), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst_l(rst_l), .bus(bus), .flush_in(flush_in),
    .count_out(count_out), .overflow_out(overflow_out), .err_cnt_out(err_cnt_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  ent_t       q[$];
  bit         m_pend_v = 1'b0;
  logic [4:0] m_pend_rd = 5'd0;
  bit         m_ovf = 1'b0;
  int         m_errc = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare every visible output against the model's current state.
  task automatic check_model();
    check_val("wb_valid", bus.wb_valid_out, q.size() != 0);
    check_val("count", count_out, q.size());
    check_val("issue_ready", bus.issue_ready_out, (q.size() + m_pend_v) < DEPTH);
    check_val("overflow", overflow_out, m_ovf);
    check_val("err_cnt", err_cnt_out, m_errc);
    if (q.size() != 0) begin
      check_val("wb_rd", bus.wb_rd_out, q[0].rd);
      check_val("wb_data", bus.wb_data_out, q[0].d);
      check_val("wb_err", bus.wb_error_out, q[0].e);
    end
  endtask

  task automatic step(input bit v, input logic [4:0] rd, input logic [31:0] d, input bit e,
                      input bit fl, input bit rdy, input bit rl);
    bit   pop;
    ent_t it;
    @(negedge clk);
    bus.valid_in    = v;
    bus.rd_addr_in  = rd;
    bus.result_ff   = d;
    bus.error       = e;
    bus.wb_ready_in = rdy;
    flush_in        = fl;
    rst_l           = rl;
    #1;
    check_model();
    @(posedge clk);
    if (!rl) begin
      q.delete();
      m_pend_v = 1'b0;
      m_ovf    = 1'b0;
      m_errc   = 0;
    end else if (fl) begin
      q.delete();
      m_pend_v = 1'b0;
    end else begin
      pop = (q.size() != 0) && rdy;
      if (pop) void'(q.pop_front());
      if (m_pend_v && m_pend_rd != 5'd0) begin
        if (q.size() == DEPTH) begin
          m_ovf = 1'b1;
        end else begin
          it.rd = m_pend_rd; it.d = d; it.e = e;
          q.push_back(it);
          if (e && m_errc < 255) m_errc++;
        end
      end
      m_pend_v = v;
    end
    m_pend_rd = rd;
    #1;
  endtask

  initial begin
    bus.valid_in = 1'b0; bus.rd_addr_in = 5'd0; bus.result_ff = 32'd0;
    bus.error = 1'b0; bus.wb_ready_in = 1'b0; flush_in = 1'b0; rst_l = 1'b0;
    step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("rst_valid", bus.wb_valid_out, 1'b0);
    check_val("rst_count", count_out, 3'd0);
    check_val("rst_iready", bus.issue_ready_out, 1'b1);
    check_val("rst_ovf", overflow_out, 1'b0);
    check_val("rst_errc", err_cnt_out, 8'd0);

    // Single op, two-cycle latency
    step(1'b1, 5'd5, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 5'd0, 32'h0000_00FF, 1'b0, 1'b0, 1'b0, 1'b1);
    check_val("single_valid", bus.wb_valid_out, 1'b1);
    check_val("single_rd", bus.wb_rd_out, 5'd5);
    check_val("single_data", bus.wb_data_out, 32'h0000_00FF);
    step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    check_val("single_drained", count_out, 3'd0);

    // Fill and overflow
    for (int i = 1; i <= 5; i++) step(1'b1, 5'(i), $urandom, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 5'd0, $urandom, 1'b0, 1'b0, 1'b0, 1'b1);
    check_val("fill_count", count_out, 3'd4);
    check_val("fill_ovf", overflow_out, 1'b1);
    check_val("fill_iready", bus.issue_ready_out, 1'b0);
    check_val("fill_head", bus.wb_rd_out, 5'd1);
    for (int i = 1; i <= 4; i++) begin
      check_val("drain_order", bus.wb_rd_out, 5'(i));
      step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    end

    // x0 discard and error counting
    step(1'b1, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 5'd0, 32'h1234, 1'b1, 1'b0, 1'b0, 1'b1);
    check_val("x0_count", count_out, 3'd0);
    check_val("x0_errc", err_cnt_out, 8'd0);
    step(1'b1, 5'd3, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 5'd0, 32'h55, 1'b1, 1'b0, 1'b0, 1'b1);
    check_val("err_head", bus.wb_error_out, 1'b1);
    check_val("err_cnt1", err_cnt_out, 8'd1);
    step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Flush with 3 queued plus 1 pending
    for (int i = 0; i < 4; i++) step(1'b1, 5'(10 + i), $urandom, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 5'd0, $urandom, 1'b1, 1'b1, 1'b0, 1'b1);
    check_val("flush_count", count_out, 3'd0);
    check_val("flush_valid", bus.wb_valid_out, 1'b0);
    check_val("flush_ovf", overflow_out, 1'b1);
    check_val("flush_errc", err_cnt_out, 8'd1);
    step(1'b0, 5'd0, $urandom, 1'b0, 1'b0, 1'b0, 1'b1);
    check_val("flush_no_push", count_out, 3'd0);

    // Reset mid-operation
    step(1'b1, 5'd7, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 5'd8, $urandom, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 5'd0, $urandom, 1'b0, 1'b0, 1'b0, 1'b1);
    check_val("pre_rst_count", count_out, 3'd2);
    step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("mrst_count", count_out, 3'd0);
    check_val("mrst_valid", bus.wb_valid_out, 1'b0);
    check_val("mrst_ovf", overflow_out, 1'b0);
    check_val("mrst_errc", err_cnt_out, 8'd0);
    check_val("mrst_iready", bus.issue_ready_out, 1'b1);
    step(1'b1, 5'd9, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 5'd0, 32'hCAFE_0009, 1'b0, 1'b0, 1'b0, 1'b1);
    check_val("post_rst_rd", bus.wb_rd_out, 5'd9);
    check_val("post_rst_data", bus.wb_data_out, 32'hCAFE_0009);
    step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Full queue with simultaneous push and pop
    for (int i = 1; i <= 4; i++) step(1'b1, 5'(i), $urandom, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 5'd20, $urandom, 1'b0, 1'b0, 1'b0, 1'b1);
    check_val("full_count", count_out, 3'd4);
    step(1'b0, 5'd0, 32'hABCD_0014, 1'b0, 1'b0, 1'b1, 1'b1);
    check_val("full_pp_count", count_out, 3'd4);
    check_val("full_pp_ovf", overflow_out, 1'b0);
    check_val("full_pp_head", bus.wb_rd_out, 5'd2);
    for (int i = 0; i < 4; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Error counter saturation
    for (int i = 0; i < 300; i++) step(1'b1, 5'd3, $urandom, 1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b0, 5'd0, $urandom, 1'b1, 1'b0, 1'b1, 1'b1);
    check_val("err_sat", err_cnt_out, 8'd255);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), $urandom, $urandom_range(0, 7) == 0,
           $urandom_range(0, 40) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 400) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
